// File: rtl/pll_reset_supervisor.sv
// Reset sequencer for the SDRAM clock PLL: holds the PLL in reset, waits for a
// qualified lock, retries on timeout and drops the SDRAM domain if lock is lost.
module pll_reset_supervisor #(
    parameter int RST_HOLD     = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 1024,
    parameter int CNT_W        = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       clr_status,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       timeout_pulse,
    output logic       lock_lost,
    output logic [7:0] retry_cnt
);

    typedef enum logic [1:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABILIZE,
        RUN
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] TMO_END  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_END  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             lock_meta;
    logic             locked_s;
    logic             tmo;
    logic             lost_set;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tmo     = 1'b0;
        unique case (state)
            RESET_PLL: begin
                if (cnt == HOLD_END) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            WAIT_LOCK: begin
                // lock seen in the same cycle as the timeout still wins
                if (locked_s) begin
                    state_n = STABILIZE;
                    cnt_n   = '0;
                end else if (cnt == TMO_END) begin
                    state_n = RESET_PLL;
                    cnt_n   = '0;
                    tmo     = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == STB_END) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_n = RESET_PLL;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = RESET_PLL;
                cnt_n   = '0;
            end
        endcase
    end

    assign lost_set = (state == RUN) && (state_n == RESET_PLL);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_meta     <= 1'b0;
            locked_s      <= 1'b0;
            state         <= RESET_PLL;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
            timeout_pulse <= 1'b0;
            lock_lost     <= 1'b0;
            retry_cnt     <= 8'd0;
        end else begin
            lock_meta     <= pll_locked;
            locked_s      <= lock_meta;
            state         <= state_n;
            cnt           <= cnt_n;
            // outputs follow the next state so they move with the state register
            pll_rst       <= (state_n == RESET_PLL);
            sys_rst       <= (state_n != RUN);
            ready         <= (state_n == RUN);
            timeout_pulse <= tmo;
            if (tmo && (retry_cnt != 8'hFF)) begin
                retry_cnt <= retry_cnt + 8'd1;
            end
            if (lost_set) begin
                lock_lost <= 1'b1;
            end else if (clr_status) begin
                lock_lost <= 1'b0;
            end
        end
    end

endmodule
